gpio_input_conditioner: RTL and testbench

GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

---
 rtl/gpio_input_conditioner.sv | 110 +++++++++++
 tb/tb_gpio_input_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// gpio_input_conditioner -- 2-flop sync, per-pin debounce and edge pulses. Rev 1.0
// Optional: define GPIO_EDGE_IRQ_EN to add sticky per-pin edge interrupt flags.
module gpio_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [7:0]  IO,
   input  logic [15:0] Mode,
   input  logic [7:0]  IrqEnable,
   input  logic [7:0]  IrqClear,
   output logic [7:0]  Input,
   output logic [7:0]  Rise,
   output logic [7:0]  Fall,
   output logic [7:0]  IrqPending,
   output logic        Irq
);
   localparam logic [15:0] c_CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic [7:0] r_sync1;
   logic [7:0] r_sync2;
   logic [7:0] r_input;
   logic [7:0] r_rise;
   logic [7:0] r_fall;
   logic [7:0] r_db_prev;
   logic [7:0] w_out_mode;
   logic [7:0] w_db_en;
   logic [7:0] w_input_nxt;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_input   <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_db_prev <= '0;
      end else begin
         r_sync1   <= IO;
         r_sync2   <= r_sync1;
         r_input   <= w_input_nxt;
         r_rise    <= w_input_nxt & ~r_input;
         r_fall    <= ~w_input_nxt & r_input;
         r_db_prev <= w_db_en;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_pin
      logic [15:0] r_cnt;
      logic        w_hold;
      logic        w_differ;
      logic        w_expire;
      logic        w_load;

      assign w_out_mode[gi] = Mode[2*gi];
      assign w_db_en[gi]    = Mode[2*gi+1];

      // A flip of the debounce enable freezes the pin for one cycle and restarts its count.
      assign w_hold   = w_out_mode[gi] | (w_db_en[gi] ^ r_db_prev[gi]);
      assign w_differ = r_sync2[gi] ^ r_input[gi];
      assign w_expire = w_differ & (r_cnt == c_CNT_MAX);
      assign w_load   = ~w_hold & (~w_db_en[gi] | w_expire);

      assign w_input_nxt[gi] = w_load ? r_sync2[gi] : r_input[gi];

      always_ff @(posedge Clock or negedge Reset_n) begin
         if (!Reset_n) begin
            r_cnt <= '0;
         end else if (w_hold || !w_db_en[gi] || !w_differ || w_expire) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

`ifdef GPIO_EDGE_IRQ_EN
   logic [7:0] r_pend;
   logic       r_irq;
   logic [7:0] w_pend_nxt;

   // Set has priority over a simultaneous clear.
   assign w_pend_nxt = (r_pend & ~IrqClear) | ((r_rise | r_fall) & IrqEnable);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pend <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_irq  <= |w_pend_nxt;
      end
   end

   assign IrqPending = r_pend;
   assign Irq        = r_irq;
`else
   logic w_unused_irq;
   assign w_unused_irq = ^{IrqEnable, IrqClear};
   assign IrqPending   = '0;
   assign Irq          = 1'b0;
`endif

   assign Input = r_input;
   assign Rise  = r_rise;
   assign Fall  = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// Bench for gpio_input_conditioner: directed literal checks plus randomized run vs. a history-based model.
module tb_gpio_input_conditioner;
   localparam int D = 16;
`ifdef GPIO_EDGE_IRQ_EN
   localparam bit c_IRQ = 1'b1;
`else
   localparam bit c_IRQ = 1'b0;
`endif

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic [7:0]  IO = '0;
   logic [15:0] Mode = '0;
   logic [7:0]  IrqEnable = '0;
   logic [7:0]  IrqClear = '0;
   logic [7:0]  Input;
   logic [7:0]  Rise;
   logic [7:0]  Fall;
   logic [7:0]  IrqPending;
   logic        Irq;

   int n_checks = 0;
   int n_errors = 0;

   gpio_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .IO(IO), .Mode(Mode),
      .IrqEnable(IrqEnable), .IrqClear(IrqClear), .Input(Input),
      .Rise(Rise), .Fall(Fall), .IrqPending(IrqPending), .Irq(Irq)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: edges counted since reset; IO sampled at every edge is kept so the
   // synchronized value seen at edge e is simply the pin level sampled at edge e-2.
   int        m_e;
   bit [7:0]  m_io_q[$];
   bit [7:0]  m_in, m_rise, m_fall, m_pend, m_dbprev;
   bit        m_irq;
   int        m_block[8];

   function automatic bit s_at(int k, int i);
      if (k >= 3) return m_io_q[k-3][i];
      return 1'b0;
   endfunction

   task automatic m_clear();
      m_e = 0;
      m_io_q.delete();
      m_in = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_dbprev = '0; m_irq = 1'b0;
      for (int i = 0; i < 8; i++) m_block[i] = 0;
   endtask

   task automatic m_step();
      bit [7:0] nin;
      bit       ok;
      m_e++;
      nin = m_in;
      for (int i = 0; i < 8; i++) begin
         if (Mode[2*i] || (Mode[2*i+1] != m_dbprev[i])) begin
            m_block[i] = m_e;
         end else if (!Mode[2*i+1]) begin
            nin[i] = s_at(m_e, i);
            m_block[i] = m_e;
         end else begin
            // accept only if the last D synchronized samples all show the opposite level
            ok = (m_e - D + 1) > m_block[i];
            for (int k = m_e - D + 1; ok && k <= m_e; k++)
               if (s_at(k, i) == m_in[i]) ok = 1'b0;
            if (ok) begin
               nin[i] = ~m_in[i];
               m_block[i] = m_e;
            end
         end
      end
      if (c_IRQ) begin
         m_pend = (m_pend & ~IrqClear) | ((m_rise | m_fall) & IrqEnable);
         m_irq  = |m_pend;
      end
      m_rise = nin & ~m_in;
      m_fall = ~nin & m_in;
      m_in   = nin;
      for (int i = 0; i < 8; i++) m_dbprev[i] = Mode[2*i+1];
      m_io_q.push_back(IO);
   endtask

   initial begin
      m_clear();
      forever begin
         @(posedge Clock or negedge Reset_n);
         if (!Reset_n) m_clear();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge Clock);
         chk("cmp_input", Input, m_in);
         chk("cmp_rise", Rise, m_rise);
         chk("cmp_fall", Fall, m_fall);
         chk("cmp_pend", IrqPending, m_pend);
         chk("cmp_irq", {7'd0, Irq}, {7'd0, m_irq});
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      tick(2);
      Reset_n = 1'b1;
   endtask

   initial begin
      // Plain sync path: change appears at edge 3 with a one-cycle Rise.
      Mode = 16'h0000; IO = 8'h00; IrqEnable = 8'h00; IrqClear = 8'h00;
      do_reset();
      chk("rst_input", Input, 8'h00);
      chk("rst_rise", Rise, 8'h00);
      IO = 8'hA5;
      tick(2);
      chk("t1_input_e2", Input, 8'h00);
      tick();
      chk("t1_input_e3", Input, 8'hA5);
      chk("t1_rise_e3", Rise, 8'hA5);
      chk("t1_fall_e3", Fall, 8'h00);
      tick();
      chk("t1_rise_e4", Rise, 8'h00);

      // Debounce: a 10-cycle glitch is rejected, a long level lands at edge 18.
      Mode = 16'h0002; IO = 8'h00;
      do_reset();
      IO = 8'h01;
      tick(10);
      IO = 8'h00;
      tick(20);
      chk("t2_glitch", Input, 8'h00);
      IO = 8'h01;
      tick(17);
      chk("t2_e17", Input, 8'h00);
      tick();
      chk("t2_e18", Input, 8'h01);
      chk("t2_rise", Rise, 8'h01);

      // Output mode holds; returning to input produces a normal edge.
      Mode = 16'h0001; IO = 8'h00;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         IO[0] = ~IO[0];
         tick();
         chk("t3_out_rf", Rise | Fall, 8'h00);
      end
      IO = 8'h00;
      tick(3);
      chk("t3_held", Input, 8'h00);
      Mode = 16'h0000; IO = 8'h01;
      tick(2);
      chk("t3_e2", Input, 8'h00);
      tick();
      chk("t3_e3", Input, 8'h01);
      chk("t3_rise", Rise, 8'h01);

      // Sticky edge interrupt (or tied-off flags in the default build).
      Mode = 16'h0000; IO = 8'h00; IrqEnable = c_IRQ ? 8'h01 : 8'hFF;
      do_reset();
      IO = 8'h01;
      tick(4);
      chk("t4_pend_set", IrqPending, c_IRQ ? 8'h01 : 8'h00);
      chk("t4_irq_set", {7'd0, Irq}, {7'd0, c_IRQ});
      tick(2);
      IO = 8'h00;
      tick(3);
      chk("t4_fall", Fall, 8'h01);
      IrqClear = 8'h01;
      tick();
      chk("t4_set_wins", IrqPending, c_IRQ ? 8'h01 : 8'h00);
      tick();
      chk("t4_cleared", IrqPending, 8'h00);
      chk("t4_irq_clr", {7'd0, Irq}, 8'h00);
      IrqClear = 8'h00;
      IrqEnable = 8'h00;

      // Asynchronous reset in the middle of a debounce count.
      Mode = 16'h0002; IO = 8'h00;
      do_reset();
      IO = 8'hFF;
      tick(10);
      chk("t5_pre", Input, 8'hFE);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("t5_async_in", Input, 8'h00);
      chk("t5_async_rf", Rise | Fall, 8'h00);
      chk("t5_async_pend", IrqPending, 8'h00);
      chk("t5_async_irq", {7'd0, Irq}, 8'h00);
      @(posedge Clock); #1;
      Reset_n = 1'b1;
      tick(17);
      chk("t5_e17", Input, 8'hFE);
      tick();
      chk("t5_e18", Input, 8'hFF);
      chk("t5_rise", Rise, 8'h01);

      // Randomized run against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge Clock); #1;
         for (int i = 0; i < 8; i++)
            if ($urandom_range(0, 11) == 0) IO[i] = ~IO[i];
         if ($urandom_range(0, 49) == 0) Mode = 16'($urandom);
         IrqEnable = 8'($urandom);
         IrqClear  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         if (!Reset_n) Reset_n = 1'b1;
         else if ($urandom_range(0, 999) == 0) Reset_n = 1'b0;
      end
      Reset_n = 1'b1;
      tick(4);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
